piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in/serial-out transmitter: the serialising end of the team's shift-register datapath, feeding the serial-in/parallel-out receiver side. It accepts WIDTH-bit parallel words through a valid/ready handshake. Each word is shifted out one bit per clock with a frame-valid and last-bit marker. A one-word holding buffer keeps back-to-back words streaming with no idle bit slot between them.

## Interface
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pi  input  WIDTH  parallel word to transmit.
- pi_valid  input  1  pi holds a word to send.
- pi_ready  output  1  block can accept a word this cycle; a word transfers on a rising edge with pi_valid=1 and pi_ready=1.
- so  output  1  serial data bit, registered.
- so_valid  output  1  so carries a valid bit this cycle, registered.
- so_last  output  1  current so bit is the final bit of its word, registered.
- busy  output  1  shifter active or holding buffer full.

## Operation
- Storage:
  - shift register sreg[WIDTH-1:0];
  - bit counter cnt, width $clog2(WIDTH);
  - holding register hold[WIDTH-1:0] with flag hold_full.
- pi_ready = reset & ~hold_full. It is derived from registered state only and never depends combinationally on pi_valid.
- FSM states:
  - IDLE: so_valid=0.
  - SHIFT: so_valid=1, one bit per cycle.
- Acceptance routing at an edge with pi_valid & pi_ready:
  - If the FSM is in IDLE, or in SHIFT on the last bit, and hold is empty, the word loads directly into sreg. The FSM is in SHIFT with cnt=0 after the edge.
  - Otherwise the word loads into hold and hold_full is set.
- End of word: at the edge ending the last bit (cnt=WIDTH-1):
  - if hold_full, hold moves to sreg, hold_full clears, and cnt resets to 0, so SHIFT continues with no gap;
  - else if a direct-load word is accepted, it loads into sreg, with no gap;
  - else the FSM goes to IDLE.
- Output bit: so is sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0]. sreg shifts toward the output end each SHIFT cycle.
- so_last = so_valid & (cnt == WIDTH-1).
- busy = (state == SHIFT) | hold_full.
- Output gating: in IDLE, so is driven 0, not the stale bit.
- A word is never dropped or duplicated. pi is ignored unless a transfer occurs.
- Reset is asynchronous. Asserting it mid-word aborts the word and discards hold. No partial word resumes after release.

## Timing
- Reset values: so=0, so_valid=0, so_last=0, pi_ready=0 (while reset=0), busy=0, FSM in IDLE, hold_full=0, cnt=0.
- After reset release, pi_ready=1 in the first cycle.
- Latency: a word accepted at edge k from IDLE presents bit i during cycle k+i, for i=0..WIDTH-1. so_last is high during cycle k+WIDTH-1.
- Throughput: 1 bit per clock sustained. A word loaded into hold before its predecessor's last bit starts exactly at cycle k+WIDTH.
- Handshake: the host may hold pi_valid=1 with pi stable across pi_ready=0 cycles. Only the edge with both signals high transfers the word.
- Simultaneous events:
  - Last bit with hold full: pi_ready=0 that cycle. Hold drains to sreg and pi_ready returns to 1 the next cycle.
  - Last bit with hold empty and pi_valid=1: direct load, no gap.
- Maximum buffering: 2 words (sreg + hold).

## Test plan
- Reset: hold reset=0 for 2 edges while pi_valid=1, pi=4'b1111 -> so/so_valid/so_last/busy stay 0, pi_ready=0. After release, pi_ready=1 and nothing is transmitted.
- Single word, MSB_FIRST=1: pi=4'b1100 accepted at edge k -> so=1,1,0,0 in cycles k..k+3. so_valid=1 for exactly 4 cycles. so_last only in cycle k+3. IDLE in cycle k+4.
- Back-to-back: 4'b1010 then 4'b0101 offered on consecutive cycles -> continuous stream 1,0,1,0,0,1,0,1 with no so_valid gap. pi_ready=0 while hold is full. so_last is high twice.
- LSB-first: MSB_FIRST=0, pi=4'b1001 followed by 4'b0001 -> first word 1,0,0,1, then second word 1,0,0,0.
- Backpressure: pi_valid held high with three words queued, each presented until accepted -> exactly three words appear serially, in order, none lost or repeated.
- Reset mid-word: reset=0 asserted asynchronously during bit 2 of 4'b1100 with hold full -> outputs drop to reset values immediately. After release, no remaining bits or held word are emitted.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer so that
// back-to-back words stream out with no idle bit slot between them.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept, is_last, direct;

    assign pi_ready = reset & ~hold_full;
    assign accept   = pi_valid & pi_ready;
    assign is_last  = (state == SHIFT) && (cnt == LAST);
    // A new word goes straight to the shifter only when the shifter is free
    // at this edge and nothing is already waiting in hold.
    assign direct   = accept & ((state == IDLE) | is_last) & ~hold_full;
    assign shifted  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign busy     = (state == SHIFT) | hold_full;

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        cnt_n       = cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        if (is_last && hold_full) begin
            sreg_n      = hold;
            cnt_n       = '0;
            hold_full_n = 1'b0;
        end else if (direct) begin
            sreg_n  = pi;
            cnt_n   = '0;
            state_n = SHIFT;
        end else if (is_last) begin
            cnt_n   = '0;
            state_n = IDLE;
        end else if (state == SHIFT) begin
            sreg_n = shifted;
            cnt_n  = cnt + CW'(1);
        end
        if (accept && !direct) begin
            hold_n      = pi;
            hold_full_n = 1'b1;
        end
    end

    // Serial outputs are registered from next-state values so they line up
    // with the word being presented in the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            so        <= 1'b0;
            so_valid  <= 1'b0;
            so_last   <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            so        <= (state_n == SHIFT) &
                         (MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0]);
            so_valid  <= (state_n == SHIFT);
            so_last   <= (state_n == SHIFT) && (cnt_n == LAST);
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share one stimulus
// stream and are checked against a bit-queue model of the serial output.
module tb_piso_tx;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pi = '0;
    logic         pi_valid = 1'b0;
    logic         r1, so1, sv1, sl1, b1;
    logic         r0, so0, sv0, sl0, b0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .pi(pi), .pi_valid(pi_valid), .pi_ready(r1),
        .so(so1), .so_valid(sv1), .so_last(sl1), .busy(b1));
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .pi(pi), .pi_valid(pi_valid), .pi_ready(r0),
        .so(so0), .so_valid(sv0), .so_last(sl0), .busy(b0));

    typedef struct packed {logic b; logic l;} ent_t;
    ent_t qm[$], ql[$];
    ent_t cm, cl;
    logic cv, acc = 1'b0, exp_rdy = 1'b0;
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("so_msb", so1, cm.b);   chk("so_lsb", so0, cl.b);
        chk("valid_msb", sv1, cv);  chk("valid_lsb", sv0, cv);
        chk("last_msb", sl1, cm.l); chk("last_lsb", sl0, cl.l);
        chk("busy_msb", b1, cv || qm.size() >= W);
        chk("busy_lsb", b0, cv || qm.size() >= W);
        chk("ready_msb", r1, exp_rdy);
        chk("ready_lsb", r0, exp_rdy);
    endtask

    // One clock: record any transfer as a word's worth of bits, present the
    // next bit, then compare. A second word waiting behind the current one
    // means the buffer is full.
    task automatic step();
        @(posedge clk);
        acc = reset && pi_valid && exp_rdy;
        if (acc)
            for (int i = 0; i < W; i++) begin
                qm.push_back('{pi[W-1-i], i == W-1});
                ql.push_back('{pi[i], i == W-1});
            end
        cv = (qm.size() > 0);
        if (cv) begin cm = qm.pop_front(); cl = ql.pop_front(); end
        else begin cm = '0; cl = '0; end
        #1;
        exp_rdy = reset && (qm.size() < W);
        chk_all();
    endtask

    task automatic offer(input logic [W-1:0] w);
        int n;
        pi = w; pi_valid = 1'b1; n = 0;
        do begin step(); n++; end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        pi_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        qm.delete(); ql.delete();
        cv = 1'b0; cm = '0; cl = '0; exp_rdy = 1'b0;
        chk_all();
        pi = 4'b1111; pi_valid = 1'b1;
        step(); step();
        reset = 1'b1;
        exp_rdy = 1'b1;
        #1;
        chk("ready_after_rel_msb", r1, 1'b1);
        chk("ready_after_rel_lsb", r0, 1'b1);
        idle(3);
    endtask

    initial begin
        #2;
        do_reset();
        // single word
        offer(4'b1100); idle(6);
        // back-to-back through hold
        offer(4'b1010); offer(4'b0101); idle(10);
        // LSB-first ordering pair
        offer(4'b1001); offer(4'b0001); idle(10);
        // three words with backpressure
        offer(4'b0110); offer(4'b1011); offer(4'b0011); idle(14);
        // reset during bit 2 with hold full
        offer(4'b1100); offer(4'b1111); step();
        do_reset();
        idle(8);
        // random traffic; pi stays stable until transferred
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pi_valid || acc) begin
                pi_valid = ($urandom_range(0, 3) != 0);
                pi = W'($urandom);
            end
            step();
        end
        idle(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
